// File: rtl/chr_gen_pkg.sv
// Shared definitions for the character generator text path: screen geometry,
// control codes, fill character and the text writer state encoding.
package chr_gen_pkg;

    localparam int unsigned C_COLS   = 32;
    localparam int unsigned C_ROWS   = 32;
    localparam int unsigned C_CHR_H  = 8;
    localparam int unsigned COL_W    = $clog2(C_COLS);
    localparam int unsigned ROW_W    = $clog2(C_ROWS);
    localparam int unsigned ADDR_W   = COL_W + ROW_W;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned SCROLL_W = 8;

    localparam logic [DATA_W-1:0] C_SPACE  = 8'h20;
    localparam logic [DATA_W-1:0] CC_BS    = 8'h08;
    localparam logic [DATA_W-1:0] CC_TAB   = 8'h09;
    localparam logic [DATA_W-1:0] CC_LF    = 8'h0A;
    localparam logic [DATA_W-1:0] CC_FF    = 8'h0C;
    localparam logic [DATA_W-1:0] CC_CR    = 8'h0D;
    localparam logic [DATA_W-1:0] PRINT_LO = 8'h20;
    localparam logic [DATA_W-1:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        CLR_LINE = 2'd2,
        CLR_ALL  = 2'd3
    } state_t;

    // Codes that produce a glyph in VRAM.
    function automatic logic is_printable(input logic [DATA_W-1:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

    // Scroll row expressed in scanlines, wrapped to the scroll register width.
    function automatic logic [SCROLL_W-1:0] scroll_px(input logic [ROW_W-1:0] r);
        return SCROLL_W'(32'(r) * C_CHR_H);
    endfunction

endpackage

// File: rtl/vram_text_writer_if.sv
// Byte-stream input and VRAM/scroll output bundle of the text writer.
//   dat/dat_v/dat_rdy : input byte handshake (DATs_i / DAT_V_i / DAT_RDY_o)
//   vram_wd/wa/we     : VRAM write port (VRAM_WDs_o / VRAM_WAs_o / VRAM_WE_o)
//   v_scroll          : vertical scroll in scanlines (V_SCROLLs_o)
//   busy              : clear sequence in progress (BUSY_o)
// master = byte source / VRAM consumer side, slave = text writer.
interface vram_text_writer_if;
    import chr_gen_pkg::*;

    logic [DATA_W-1:0]   dat;
    logic                dat_v;
    logic                dat_rdy;
    logic [DATA_W-1:0]   vram_wd;
    logic [ADDR_W-1:0]   vram_wa;
    logic                vram_we;
    logic [SCROLL_W-1:0] v_scroll;
    logic                busy;

    modport master (
        output dat, dat_v,
        input  dat_rdy, vram_wd, vram_wa, vram_we, v_scroll, busy
    );

    modport slave (
        input  dat, dat_v,
        output dat_rdy, vram_wd, vram_wa, vram_we, v_scroll, busy
    );

endinterface

// File: rtl/vram_clr_seq.sv
// Address generator for screen clears: walks one physical row (start_line)
// or the whole VRAM (start_all), advancing one word per step.
//   clk, rst    : clock, async active-high reset (resets into a full clear)
//   start_line  : begin clearing physical row base_row
//   start_all   : begin clearing addresses 0..C_COLS*C_ROWS-1
//   step        : advance to the next word
//   base_row    : physical row captured on start_line
//   wa_c, we_c  : current clear address and active flag
//   done_c      : current address is the last of the sequence
module vram_clr_seq
    import chr_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_line,
    input  logic              start_all,
    input  logic              step,
    input  logic [ROW_W-1:0]  base_row,
    output logic [ADDR_W-1:0] wa_c,
    output logic              we_c,
    output logic              done_c
);

    logic [ADDR_W-1:0] ctr;
    logic [ROW_W-1:0]  base;
    logic              all_mode;
    logic              active;

    // Sequence counter; reset leaves it armed for the power-up full clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr      <= '0;
            base     <= '0;
            all_mode <= 1'b1;
            active   <= 1'b1;
        end else if (start_all) begin
            ctr      <= '0;
            all_mode <= 1'b1;
            active   <= 1'b1;
        end else if (start_line) begin
            ctr      <= '0;
            base     <= base_row;
            all_mode <= 1'b0;
            active   <= 1'b1;
        end else if (step && active) begin
            if (done_c) begin
                active <= 1'b0;
            end else begin
                ctr <= ctr + ADDR_W'(1);
            end
        end
    end

    // Line mode keeps the row fixed and uses the low counter bits as column.
    always_comb begin
        wa_c   = all_mode ? ctr : {base, ctr[COL_W-1:0]};
        we_c   = active;
        done_c = all_mode ? (ctr == ADDR_W'(C_COLS * C_ROWS - 1))
                          : (ctr[COL_W-1:0] == COL_W'(C_COLS - 1));
    end

endmodule

// File: rtl/vram_text_writer.sv
// Console text writer: turns a byte stream into VRAM writes on a 32x32
// character screen with cursor, CR/LF/BS/FF handling, screen/line clears and
// hardware vertical scrolling through the generator's scroll offset.
//   clk, rst : clock, async active-high reset
//   bus      : vram_text_writer_if.slave (byte handshake, VRAM write port,
//              v_scroll, busy)
// Optional: define VRAM_TEXT_WRITER_TAB_EN to make 0x09 advance the cursor
// to the next multiple-of-8 column (wrapping into a newline).
module vram_text_writer
    import chr_gen_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    vram_text_writer_if.slave bus
);

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  scroll_row;

    logic              accept_c;
    logic              at_bottom_c;
    logic              last_col_c;
    logic              nl_c;
    logic              start_line_c;
    logic              start_all_c;
    logic              step_c;
    logic [ROW_W-1:0]  phys_row_c;
    logic [ROW_W-1:0]  nl_row_c;
    logic [ROW_W-1:0]  nl_scroll_c;
    logic [ADDR_W-1:0] clr_wa_c;
    logic              clr_we_c;
    logic              clr_done_c;

`ifdef VRAM_TEXT_WRITER_TAB_EN
    localparam int unsigned TAB_W = COL_W + 1;
    logic [TAB_W-1:0]  tab_col_c;
`endif

    // Cursor arithmetic and newline/clear event decode.
    always_comb begin
        accept_c    = (state == IDLE) && bus.dat_rdy && bus.dat_v;
        at_bottom_c = (row == ROW_W'(C_ROWS - 1));
        last_col_c  = (col == COL_W'(C_COLS - 1));
        phys_row_c  = row + scroll_row;
        nl_row_c    = at_bottom_c ? row : row + ROW_W'(1);
        nl_scroll_c = at_bottom_c ? scroll_row + ROW_W'(1) : scroll_row;
        nl_c        = (state == WRITE && last_col_c) ||
                      (accept_c && bus.dat == CC_LF);
`ifdef VRAM_TEXT_WRITER_TAB_EN
        tab_col_c   = {1'b0, col | COL_W'(7)} + TAB_W'(1);
        nl_c        = nl_c || (accept_c && bus.dat == CC_TAB && tab_col_c[COL_W]);
`endif
        // A newline on the bottom row scrolls and blanks the row that becomes
        // the new bottom, i.e. the physical row at the old scroll offset.
        start_line_c = nl_c && at_bottom_c;
        start_all_c  = accept_c && (bus.dat == CC_FF);
        step_c       = (state == CLR_LINE) || (state == CLR_ALL);
    end

    vram_clr_seq u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .start_line (start_line_c),
        .start_all  (start_all_c),
        .step       (step_c),
        .base_row   (scroll_row),
        .wa_c       (clr_wa_c),
        .we_c       (clr_we_c),
        .done_c     (clr_done_c)
    );

    // Main FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= CLR_ALL;
            col          <= '0;
            row          <= '0;
            scroll_row   <= '0;
            bus.dat_rdy  <= 1'b0;
            bus.vram_we  <= 1'b0;
            bus.vram_wa  <= '0;
            bus.vram_wd  <= '0;
            bus.v_scroll <= '0;
            bus.busy     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    bus.vram_we <= 1'b0;
                    if (accept_c) begin
                        bus.dat_rdy <= 1'b0;
                        if (is_printable(bus.dat)) begin
                            bus.vram_we <= 1'b1;
                            bus.vram_wa <= {phys_row_c, col};
                            bus.vram_wd <= bus.dat;
                            state       <= WRITE;
                        end else begin
                            case (bus.dat)
                                CC_CR: col <= '0;
                                CC_BS: begin
                                    if (col != '0) begin
                                        col <= col - COL_W'(1);
                                    end
                                end
                                CC_FF: begin
                                    col          <= '0;
                                    row          <= '0;
                                    scroll_row   <= '0;
                                    bus.v_scroll <= '0;
                                    bus.busy     <= 1'b1;
                                    state        <= CLR_ALL;
                                end
`ifdef VRAM_TEXT_WRITER_TAB_EN
                                // Overflow past the last column drops to 0;
                                // the newline itself is handled below.
                                CC_TAB: col <= tab_col_c[COL_W-1:0];
`endif
                                default: ;
                            endcase
                        end
                    end else begin
                        bus.dat_rdy <= 1'b1;
                        bus.busy    <= 1'b0;
                    end
                end
                WRITE: begin
                    // Column wraps to 0 naturally at the last column.
                    bus.vram_we <= 1'b0;
                    col         <= col + COL_W'(1);
                    bus.dat_rdy <= 1'b1;
                    state       <= IDLE;
                end
                CLR_LINE, CLR_ALL: begin
                    bus.vram_we <= clr_we_c;
                    bus.vram_wa <= clr_wa_c;
                    bus.vram_wd <= C_SPACE;
                    if (clr_done_c) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Newline: advance the row, or scroll once the bottom is reached.
            if (nl_c) begin
                row          <= nl_row_c;
                scroll_row   <= nl_scroll_c;
                bus.v_scroll <= scroll_px(nl_scroll_c);
            end
            if (start_line_c) begin
                state       <= CLR_LINE;
                bus.busy    <= 1'b1;
                bus.dat_rdy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_text_writer.sv
// Self-checking bench for vram_text_writer: a reference cursor model pushes
// expected VRAM writes into a queue, a negedge monitor pops and compares.
module tb_vram_text_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    vram_text_writer_if vif ();

    vram_text_writer dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    typedef struct packed {
        logic [9:0] wa;
        logic [7:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_col = 0;
    int   m_row = 0;
    int   m_scroll = 0;

    // Write monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (vif.vram_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got wa=%0d wd=%02h, required no write",
                         vif.vram_wa, vif.vram_wd);
            end else begin
                e = exp_q.pop_front();
                if (vif.vram_wa !== e.wa || vif.vram_wd !== e.wd) begin
                    bad++;
                    $display("FAIL write_seq: got wa=%0d wd=%02h, required wa=%0d wd=%02h",
                             vif.vram_wa, vif.vram_wd, e.wa, e.wd);
                end
            end
        end
    end

    task automatic push_w(input int wa, input logic [7:0] wd);
        exp_t e;
        e.wa = 10'(wa);
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic model_nl();
        if (m_row < 31) begin
            m_row++;
        end else begin
            for (int i = 0; i < 32; i++) push_w(m_scroll * 32 + i, 8'h20);
            m_scroll = (m_scroll + 1) % 32;
        end
    endtask

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        m_scroll = 0;
        for (int i = 0; i < 1024; i++) push_w(i, 8'h20);
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_w(((m_row + m_scroll) % 32) * 32 + m_col, b);
            if (m_col == 31) begin
                m_col = 0;
                model_nl();
            end else begin
                m_col++;
            end
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            model_nl();
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            model_reset();
`ifdef VRAM_TEXT_WRITER_TAB_EN
        end else if (b == 8'h09) begin
            m_col = (m_col | 7) + 1;
            if (m_col >= 32) begin
                m_col = 0;
                model_nl();
            end
`endif
        end
    endtask

    // Waits for RDY, presents one byte for a single accept; returns in the
    // cycle after acceptance (where a printable's WE is visible).
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (vif.dat_rdy !== 1'b1 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (vif.dat_rdy !== 1'b1) begin
            bad++;
            $display("FAIL rdy_timeout: got rdy=%0b, required 1 within 3000 cycles", vif.dat_rdy);
        end
        model_byte(b);
        vif.dat   = b;
        vif.dat_v = 1'b1;
        @(negedge clk); #1;
        vif.dat_v = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && vif.dat_rdy === 1'b1) && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0 || vif.dat_rdy !== 1'b1) begin
            bad++;
            $display("FAIL idle_timeout: got pending=%0d rdy=%0b, required 0 and 1",
                     exp_q.size(), vif.dat_rdy);
        end
    endtask

    task automatic test_reset();
        int errs = 0;
        int n = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (vif.vram_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %0b required 0", vif.vram_we); end
        total++; if (vif.vram_wa !== 10'd0) begin bad++; $display("FAIL reset_wa: got %0d required 0", vif.vram_wa); end
        total++; if (vif.vram_wd !== 8'h00) begin bad++; $display("FAIL reset_wd: got %02h required 00", vif.vram_wd); end
        total++; if (vif.dat_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %0b required 0", vif.dat_rdy); end
        total++; if (vif.v_scroll !== 8'd0) begin bad++; $display("FAIL reset_vscroll: got %0d required 0", vif.v_scroll); end
        total++; if (vif.busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %0b required 1", vif.busy); end
        model_reset();
        rst = 1'b0;
        while (exp_q.size() != 0 && n < 1200) begin
            @(negedge clk); #1;
            n++;
            if (vif.busy !== 1'b1 || vif.dat_rdy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL clear_flags: got %0d cycles with busy!=1 or rdy!=0, required 0", errs); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL clear_count: got %0d writes missing, required 0", exp_q.size()); end
        @(negedge clk); #1;
        total++; if (vif.dat_rdy !== 1'b1) begin bad++; $display("FAIL post_clear_rdy: got %0b required 1", vif.dat_rdy); end
        total++; if (vif.busy !== 1'b0) begin bad++; $display("FAIL post_clear_busy: got %0b required 0", vif.busy); end
    endtask

    task automatic test_basic();
        send_byte(8'h41);
        total++; if (vif.vram_we !== 1'b1 || vif.vram_wa !== 10'd0 || vif.vram_wd !== 8'h41) begin
            bad++; $display("FAIL first_char: got we=%0b wa=%0d wd=%02h, required 1 0 41", vif.vram_we, vif.vram_wa, vif.vram_wd); end
        send_byte(8'h0D);
        send_byte(8'h0A);
        send_byte(8'h42);
        total++; if (vif.vram_wa !== 10'd32 || vif.vram_wd !== 8'h42) begin
            bad++; $display("FAIL crlf_char: got wa=%0d wd=%02h, required 32 42", vif.vram_wa, vif.vram_wd); end
        wait_idle();
    endtask

    task automatic test_wrap();
        send_byte(8'h0C);
        wait_idle();
        for (int i = 0; i < 32; i++) begin
            send_byte(8'h43);
            total++; if (vif.vram_wa !== 10'(i)) begin
                bad++; $display("FAIL wrap_col%0d: got wa=%0d, required %0d", i, vif.vram_wa, i); end
        end
        send_byte(8'h44);
        total++; if (vif.vram_wa !== 10'd32 || vif.vram_wd !== 8'h44) begin
            bad++; $display("FAIL wrap_next: got wa=%0d wd=%02h, required 32 44", vif.vram_wa, vif.vram_wd); end
        total++; if (vif.v_scroll !== 8'd0) begin bad++; $display("FAIL wrap_vscroll: got %0d required 0", vif.v_scroll); end
        wait_idle();
    endtask

    task automatic test_scroll();
        int errs = 0;
        send_byte(8'h0C);
        wait_idle();
        for (int i = 0; i < 31; i++) send_byte(8'h0A);
        total++; if (vif.v_scroll !== 8'd0) begin bad++; $display("FAIL no_scroll_yet: got %0d required 0", vif.v_scroll); end
        send_byte(8'h0A);
        total++; if (vif.v_scroll !== 8'd8) begin bad++; $display("FAIL scroll1_vscroll: got %0d required 8", vif.v_scroll); end
        total++; if (vif.busy !== 1'b1) begin bad++; $display("FAIL scroll1_busy: got %0b required 1", vif.busy); end
        wait_idle();
        send_byte(8'h0D);
        send_byte(8'h45);
        total++; if (vif.vram_wa !== 10'd0 || vif.vram_wd !== 8'h45) begin
            bad++; $display("FAIL scroll_char: got wa=%0d wd=%02h, required 0 45", vif.vram_wa, vif.vram_wd); end
        for (int i = 0; i < 31; i++) begin
            send_byte(8'h0A);
            if (vif.v_scroll !== 8'(m_scroll * 8)) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL scroll_steps: got %0d wrong v_scroll values, required 0", errs); end
        total++; if (vif.v_scroll !== 8'd0) begin bad++; $display("FAIL scroll_wrap: got %0d required 0", vif.v_scroll); end
        wait_idle();
        // Fill the bottom row to its last column: write then scroll.
        send_byte(8'h0D);
        for (int i = 0; i < 32; i++) send_byte(8'h4C);
        total++; if (vif.vram_wa !== 10'd1023 || vif.vram_wd !== 8'h4C) begin
            bad++; $display("FAIL bottom_last: got wa=%0d wd=%02h, required 1023 4c", vif.vram_wa, vif.vram_wd); end
        wait_idle();
        total++; if (vif.v_scroll !== 8'd8) begin bad++; $display("FAIL bottom_scroll: got %0d required 8", vif.v_scroll); end
    endtask

    task automatic test_bs();
        send_byte(8'h0D);
        send_byte(8'h08);
        total++; if (vif.vram_we !== 1'b0) begin bad++; $display("FAIL bs_col0_we: got %0b required 0", vif.vram_we); end
        @(negedge clk); #1;
        total++; if (vif.dat_rdy !== 1'b1) begin bad++; $display("FAIL bs_col0_rdy: got %0b required 1", vif.dat_rdy); end
        send_byte(8'h41);
        send_byte(8'h42);
        send_byte(8'h08);
        send_byte(8'h43);
        total++; if (vif.vram_wa[4:0] !== 5'd1) begin bad++; $display("FAIL bs_overwrite: got col=%0d required 1", vif.vram_wa[4:0]); end
        wait_idle();
    endtask

    task automatic test_hold();
        int n = 0;
        send_byte(8'h0C);
        model_byte(8'h47);
        vif.dat   = 8'h47;
        vif.dat_v = 1'b1;
        while (!(vif.vram_we === 1'b1 && vif.vram_wd === 8'h47) && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        vif.dat_v = 1'b0;
        total++; if (vif.vram_we !== 1'b1 || vif.vram_wa !== 10'd0 || vif.vram_wd !== 8'h47) begin
            bad++; $display("FAIL held_byte: got we=%0b wa=%0d wd=%02h, required 1 0 47", vif.vram_we, vif.vram_wa, vif.vram_wd); end
        wait_idle();
        total++; if (vif.vram_we !== 1'b0) begin bad++; $display("FAIL held_once: got we=%0b required 0", vif.vram_we); end
    endtask

    task automatic test_reset_mid();
        send_byte(8'h0C);
        wait_idle();
        for (int i = 0; i < 32; i++) send_byte(8'h0A);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        total++; if (vif.vram_we !== 1'b0 || vif.dat_rdy !== 1'b0 || vif.busy !== 1'b1 || vif.v_scroll !== 8'd0) begin
            bad++; $display("FAIL mid_reset: got we=%0b rdy=%0b busy=%0b vs=%0d, required 0 0 1 0",
                            vif.vram_we, vif.dat_rdy, vif.busy, vif.v_scroll); end
        exp_q.delete();
        model_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        wait_idle();
        send_byte(8'h41);
        total++; if (vif.vram_wa !== 10'd0 || vif.vram_wd !== 8'h41) begin
            bad++; $display("FAIL after_mid_reset: got wa=%0d wd=%02h, required 0 41", vif.vram_wa, vif.vram_wd); end
        wait_idle();
    endtask

    task automatic test_tab();
        logic [4:0] exp_col;
`ifdef VRAM_TEXT_WRITER_TAB_EN
        exp_col = 5'd8;
`else
        exp_col = 5'd3;
`endif
        send_byte(8'h0D);
        send_byte(8'h61);
        send_byte(8'h62);
        send_byte(8'h63);
        send_byte(8'h09);
        send_byte(8'h46);
        total++; if (vif.vram_wa[4:0] !== exp_col || vif.vram_wd !== 8'h46) begin
            bad++; $display("FAIL tab: got col=%0d wd=%02h, required %0d 46", vif.vram_wa[4:0], vif.vram_wd, exp_col); end
        wait_idle();
    endtask

    initial begin
        vif.dat   = 8'h00;
        vif.dat_v = 1'b0;
        @(negedge clk); #1;
        test_reset();
        test_basic();
        test_wrap();
        test_scroll();
        test_bs();
        test_hold();
        test_reset_mid();
        test_tab();
        repeat (4) @(negedge clk);
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
